// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: control/status bundle between the multi-cycle control FSM and the MIPS datapath
interface mc_ctrl_fsm_if;
  logic        MIO_ready;
  logic [31:0] Inst;
  logic        zero;
  logic        MemRead;
  logic        MemWrite;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic [2:0]  ALU_operation;
  logic        err;
  logic [4:0]  state;
  modport master (
    input  MIO_ready, Inst, zero,
    output MemRead, MemWrite, IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, err, state
  );
  modport slave (
    output MIO_ready, Inst, zero,
    input  MemRead, MemWrite, IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, err, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control unit with a memory-wait watchdog that parks the CPU in ERR
module mc_ctrl_fsm #(
  parameter int WAIT_W      = 8,
  parameter int MIO_TIMEOUT = 255
) (
  input logic            clk,
  input logic            reset,
  mc_ctrl_fsm_if.master  bus
);
  typedef enum logic [4:0] {
    S_IF, S_ID, S_EX_R, S_WB_R, S_EX_I, S_WB_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_LW, S_BR, S_J, S_JR, S_LUI, S_ERR
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [WAIT_W-1:0] TMO_M1 = WAIT_W'(MIO_TIMEOUT - 1);
  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [5:0]        op, fn;
  logic [2:0]        fn_alu;
  logic              fn_ok, waiting, timeout, unused;
  assign op      = bus.Inst[31:26];
  assign fn      = bus.Inst[5:0];
  assign unused  = ^{bus.Inst[25:6], bus.zero};
  assign waiting = (state_q == S_IF || state_q == S_MEM_RD || state_q == S_MEM_WR) && !bus.MIO_ready;
  assign timeout = (MIO_TIMEOUT != 0) && waiting && (cnt_q == TMO_M1);
  assign cnt_d   = (waiting && state_d == state_q) ? cnt_q + WAIT_W'(1) : '0;
  assign bus.state = state_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    fn_alu = 3'b010;
    fn_ok  = 1'b1;
    case (fn)
      6'h20, 6'h21: fn_alu = 3'b010;
      6'h22, 6'h23: fn_alu = 3'b110;
      6'h24:        fn_alu = 3'b000;
      6'h25:        fn_alu = 3'b001;
      6'h26:        fn_alu = 3'b011;
      6'h27:        fn_alu = 3'b100;
      6'h2a:        fn_alu = 3'b111;
      6'h02:        fn_alu = 3'b101;
      default:      fn_ok  = 1'b0;
    endcase
  end
  // Everything defaults to 0 and stays 0 while reset is held, so no strobe leaks during reset.
  always_comb begin
    state_d           = state_q;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.IorD          = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegDst        = 2'b00;
    bus.RegWrite      = 1'b0;
    bus.MemtoReg      = 2'b00;
    bus.ALUSrcA       = 1'b0;
    bus.ALUSrcB       = 2'b00;
    bus.PCSource      = 2'b00;
    bus.PCWrite       = 1'b0;
    bus.PCWriteCond   = 1'b0;
    bus.Branch        = 1'b0;
    bus.ALU_operation = 3'b000;
    bus.err           = 1'b0;
    if (reset) begin
      case (state_q)
        S_IF: begin
          bus.MemRead       = 1'b1;
          bus.ALUSrcB       = 2'b01;
          bus.ALU_operation = 3'b010;
          bus.PCWrite       = 1'b1;
          bus.IRWrite       = bus.MIO_ready;
          state_d           = timeout ? S_ERR : bus.MIO_ready ? S_ID : S_IF;
        end
        S_ID: begin
          bus.ALUSrcB       = 2'b11;
          bus.ALU_operation = 3'b010;
          bus.RegWrite      = op == OP_JAL;
          bus.RegDst        = op == OP_JAL ? 2'b10 : 2'b00;
          case (op)
            OP_R:           state_d = fn == FN_JR ? S_JR : S_EX_R;
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BR;
            OP_J, OP_JAL:   state_d = S_J;
            OP_ADDI, OP_SLTI: state_d = S_EX_I;
            OP_LUI:         state_d = S_LUI;
            default:        state_d = S_IF;
          endcase
        end
        S_EX_R, S_WB_R: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALU_operation = fn_alu;
          bus.RegDst        = state_q == S_WB_R ? 2'b01 : 2'b00;
          bus.RegWrite      = state_q == S_WB_R;
          state_d           = (state_q == S_EX_R && fn_ok) ? S_WB_R : S_IF;
        end
        S_EX_I, S_WB_I: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALUSrcB       = 2'b10;
          bus.ALU_operation = op == OP_SLTI ? 3'b111 : 3'b010;
          bus.RegWrite      = state_q == S_WB_I;
          state_d           = state_q == S_EX_I ? S_WB_I : S_IF;
        end
        S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_LW: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALUSrcB       = 2'b10;
          bus.ALU_operation = 3'b010;
          bus.IorD          = state_q == S_MEM_RD || state_q == S_MEM_WR;
          bus.MemRead       = state_q == S_MEM_RD;
          bus.MemWrite      = state_q == S_MEM_WR;
          bus.MemtoReg      = state_q == S_WB_LW ? 2'b01 : 2'b00;
          bus.RegWrite      = state_q == S_WB_LW;
          state_d = state_q == S_MEM_ADDR ? (op == OP_SW ? S_MEM_WR : S_MEM_RD)
                  : state_q == S_WB_LW    ? S_IF
                  : timeout               ? S_ERR
                  : !bus.MIO_ready        ? state_q
                  : state_q == S_MEM_RD   ? S_WB_LW : S_IF;
        end
        S_BR: begin
          bus.ALUSrcA       = 1'b1;
          bus.ALU_operation = 3'b110;
          bus.PCSource      = 2'b01;
          bus.PCWriteCond   = 1'b1;
          bus.Branch        = op == OP_BEQ;
          state_d           = S_IF;
        end
        S_J, S_JR: begin
          bus.PCSource = state_q == S_J ? 2'b10 : 2'b11;
          bus.PCWrite  = 1'b1;
          state_d      = S_IF;
        end
        S_LUI: begin
          bus.MemtoReg = 2'b10;
          bus.RegWrite = 1'b1;
          state_d      = S_IF;
        end
        S_ERR:   bus.err = 1'b1;
        default: state_d = S_IF;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed vector table, watchdog/reset sequences and randomized instruction stream vs a plan-based model
module tb_mc_ctrl_fsm;
  localparam int TMO = 4;
  typedef struct packed {
    logic MemRead, MemWrite, IorD, IRWrite;
    logic [1:0] RegDst;
    logic RegWrite;
    logic [1:0] MemtoReg;
    logic ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic PCWrite, PCWriteCond, Branch;
    logic [2:0] alu;
    logic err;
  } ctl_t;
  typedef struct { ctl_t c; bit f; bit w; } step_t;
  typedef struct { bit rst; bit rdy; bit z; logic [31:0] inst; ctl_t exp; string nm; } vec_t;

  logic clk = 1'b0, reset = 1'b0;
  int errors = 0, checks = 0, cnt = 0;
  bit err_m = 1'b0;
  step_t plan[$];
  vec_t tbl[$];
  ctl_t Z, F0, F1, D, DJAL, EXADD, WBADD, MA, MR, WL, MW, BEQC, BNEC, JJ, ERRC;

  mc_ctrl_fsm_if bus();
  mc_ctrl_fsm #(.WAIT_W(8), .MIO_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL sim_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic ctl_t outs();
    return ctl_t'({bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.RegDst, bus.RegWrite,
                   bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.PCWrite,
                   bus.PCWriteCond, bus.Branch, bus.ALU_operation, bus.err});
  endfunction

  task automatic chk(input ctl_t e, input string nm);
    ctl_t a = outs();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic add(input bit rst, input bit rdy, input bit z, input logic [31:0] inst, input ctl_t exp, input string nm);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.z = z; v.inst = inst; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  function automatic logic [3:0] fnmap(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 4'b1010;
      6'h22, 6'h23: return 4'b1110;
      6'h24: return 4'b1000;
      6'h25: return 4'b1001;
      6'h26: return 4'b1011;
      6'h27: return 4'b1100;
      6'h2a: return 4'b1111;
      6'h02: return 4'b1101;
      default: return 4'b0010;
    endcase
  endfunction

  task automatic push(input ctl_t c, input bit f, input bit w);
    step_t s;
    s.c = c; s.f = f; s.w = w;
    plan.push_back(s);
  endtask

  // Expand one instruction into the per-cycle control words the spec lists for it.
  task automatic build(input logic [31:0] i);
    ctl_t c;
    logic [5:0] op = i[31:26];
    logic [3:0] fm = fnmap(i[5:0]);
    push(F1, 1'b1, 1'b1);
    c = D;
    if (op == 6'h03) begin c.RegWrite = 1'b1; c.RegDst = 2'b10; end
    push(c, 1'b0, 1'b0);
    case (op)
      6'h00:
        if (i[5:0] == 6'h08) begin
          c = Z; c.PCSource = 2'b11; c.PCWrite = 1'b1; push(c, 1'b0, 1'b0);
        end else begin
          c = Z; c.ALUSrcA = 1'b1; c.alu = fm[2:0]; push(c, 1'b0, 1'b0);
          if (fm[3]) begin c.RegDst = 2'b01; c.RegWrite = 1'b1; push(c, 1'b0, 1'b0); end
        end
      6'h23: begin push(MA, 1'b0, 1'b0); push(MR, 1'b0, 1'b1); push(WL, 1'b0, 1'b0); end
      6'h2b: begin push(MA, 1'b0, 1'b0); push(MW, 1'b0, 1'b1); end
      6'h04, 6'h05: begin c = BEQC; c.Branch = op == 6'h04; push(c, 1'b0, 1'b0); end
      6'h02, 6'h03: push(JJ, 1'b0, 1'b0);
      6'h08, 6'h0a: begin
        c = Z; c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; c.alu = op == 6'h0a ? 3'b111 : 3'b010;
        push(c, 1'b0, 1'b0); c.RegWrite = 1'b1; push(c, 1'b0, 1'b0);
      end
      6'h0f: begin c = Z; c.MemtoReg = 2'b10; c.RegWrite = 1'b1; push(c, 1'b0, 1'b0); end
      default: ;
    endcase
  endtask

  function automatic ctl_t expect_now();
    ctl_t e;
    if (err_m) return ERRC;
    e = plan[0].c;
    if (plan[0].f) e.IRWrite = bus.MIO_ready;
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] i = $urandom;
    case ($urandom_range(0, 12))
      0, 1, 2: i[31:26] = 6'h00;
      3: i[31:26] = 6'h02;
      4: i[31:26] = 6'h03;
      5: i[31:26] = 6'h04;
      6: i[31:26] = 6'h05;
      7: i[31:26] = 6'h08;
      8: i[31:26] = 6'h0a;
      9: i[31:26] = 6'h0f;
      10: i[31:26] = 6'h23;
      11: i[31:26] = 6'h2b;
      default: ;
    endcase
    if (i[31:26] == 6'h00)
      case ($urandom_range(0, 11))
        0: i[5:0] = 6'h20;
        1: i[5:0] = 6'h21;
        2: i[5:0] = 6'h22;
        3: i[5:0] = 6'h23;
        4: i[5:0] = 6'h24;
        5: i[5:0] = 6'h25;
        6: i[5:0] = 6'h26;
        7: i[5:0] = 6'h27;
        8: i[5:0] = 6'h2a;
        9: i[5:0] = 6'h02;
        10: i[5:0] = 6'h08;
        default: ;
      endcase
    return i;
  endfunction

  localparam logic [31:0] I_ADD = 32'h00221820, I_LW = 32'h8C220008, I_SW = 32'hAC220008;
  localparam logic [31:0] I_BEQ = 32'h10220004, I_BNE = 32'h14220004, I_JAL = 32'h0C000040, I_UND = 32'hFC000000;

  initial begin
    bus.MIO_ready = 1'b0; bus.Inst = '0; bus.zero = 1'b0;
    Z     = '0;
    F1    = '{MemRead:1'b1, IRWrite:1'b1, ALUSrcB:2'b01, alu:3'b010, PCWrite:1'b1, default:'0};
    F0    = '{MemRead:1'b1, ALUSrcB:2'b01, alu:3'b010, PCWrite:1'b1, default:'0};
    D     = '{ALUSrcB:2'b11, alu:3'b010, default:'0};
    DJAL  = '{ALUSrcB:2'b11, alu:3'b010, RegWrite:1'b1, RegDst:2'b10, default:'0};
    EXADD = '{ALUSrcA:1'b1, alu:3'b010, default:'0};
    WBADD = '{ALUSrcA:1'b1, alu:3'b010, RegDst:2'b01, RegWrite:1'b1, default:'0};
    MA    = '{ALUSrcA:1'b1, ALUSrcB:2'b10, alu:3'b010, default:'0};
    MR    = '{ALUSrcA:1'b1, ALUSrcB:2'b10, alu:3'b010, IorD:1'b1, MemRead:1'b1, default:'0};
    WL    = '{ALUSrcA:1'b1, ALUSrcB:2'b10, alu:3'b010, MemtoReg:2'b01, RegWrite:1'b1, default:'0};
    MW    = '{ALUSrcA:1'b1, ALUSrcB:2'b10, alu:3'b010, IorD:1'b1, MemWrite:1'b1, default:'0};
    BEQC  = '{ALUSrcA:1'b1, alu:3'b110, PCSource:2'b01, PCWriteCond:1'b1, Branch:1'b1, default:'0};
    BNEC  = '{ALUSrcA:1'b1, alu:3'b110, PCSource:2'b01, PCWriteCond:1'b1, default:'0};
    JJ    = '{PCSource:2'b10, PCWrite:1'b1, default:'0};
    ERRC  = '{err:1'b1, default:'0};

    add(0, 1, 0, I_ADD, Z, "reset_zero");
    add(1, 1, 0, I_ADD, F1, "add_if");
    add(1, 1, 0, I_ADD, D, "add_id");
    add(1, 1, 0, I_ADD, EXADD, "add_ex");
    add(1, 1, 0, I_ADD, WBADD, "add_wb");
    add(1, 1, 0, I_LW, F1, "lw_if");
    add(1, 1, 0, I_LW, D, "lw_id");
    add(1, 1, 0, I_LW, MA, "lw_addr");
    for (int k = 0; k < 3; k++) add(1, 0, 0, I_LW, MR, "lw_wait");
    add(1, 1, 0, I_LW, MR, "lw_rd");
    add(1, 1, 0, I_LW, WL, "lw_wb");
    add(1, 1, 1, I_BEQ, F1, "beq_if");
    add(1, 1, 1, I_BEQ, D, "beq_id");
    add(1, 1, 1, I_BEQ, BEQC, "beq_br");
    add(1, 1, 1, I_BNE, F1, "bne_if");
    add(1, 1, 1, I_BNE, D, "bne_id");
    add(1, 1, 1, I_BNE, BNEC, "bne_br");
    add(1, 1, 0, I_JAL, F1, "jal_if");
    add(1, 1, 0, I_JAL, DJAL, "jal_id");
    add(1, 1, 0, I_JAL, JJ, "jal_j");
    add(1, 1, 0, I_UND, F1, "und_if");
    add(1, 1, 0, I_UND, D, "und_id");
    add(1, 0, 0, I_UND, F0, "und_back_if");
    add(1, 1, 0, I_SW, F1, "sw_if");
    add(1, 1, 0, I_SW, D, "sw_id");
    add(1, 1, 0, I_SW, MA, "sw_addr");
    add(1, 0, 0, I_SW, MW, "sw_wr");

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      reset = tbl[k].rst; bus.MIO_ready = tbl[k].rdy; bus.zero = tbl[k].z; bus.Inst = tbl[k].inst;
      #1 chk(tbl[k].exp, tbl[k].nm);
    end

    // Reset asserted while a store is still waiting on memory.
    @(negedge clk);
    #1 chk(MW, "sw_hold");
    reset = 1'b0;
    #1 chk(Z, "rst_memwr");
    // Watchdog: memory never answers the fetch.
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      #1 chk(F0, "wd_if");
      @(negedge clk);
    end
    #1 chk(ERRC, "wd_err");
    bus.MIO_ready = 1'b1;
    @(negedge clk);
    #1 chk(ERRC, "wd_sticky");
    reset = 1'b0;
    #1 chk(Z, "wd_rst");
    @(negedge clk);
    reset = 1'b1;
    #1 chk(F1, "wd_recover");

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    plan.delete(); cnt = 0; err_m = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b0;
        #1 chk(Z, "rnd_reset");
        @(negedge clk);
        reset = 1'b1;
        plan.delete(); cnt = 0; err_m = 1'b0;
      end
      if (plan.size() == 0) begin
        bus.Inst = rnd_inst();
        build(bus.Inst);
      end
      bus.MIO_ready = $urandom_range(0, 9) < 7;
      bus.zero = 1'($urandom_range(0, 1));
      #1 chk(expect_now(), "rnd");
      @(posedge clk);
      if (!err_m) begin
        if (plan[0].w && !bus.MIO_ready) begin
          cnt++;
          if (cnt == TMO) err_m = 1'b1;
        end else begin
          cnt = 0;
          void'(plan.pop_front());
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
